// File: rtl/audio_sample_fetcher.sv
// Double-buffered PCM sample prefetcher: reads little-endian 16-bit frames from the active RAM half.
// Optional AUDIO_FETCH_UNDERRUN_CNT_EN adds a saturating 16-bit underrun event counter port.
module audio_sample_fetcher #(
    parameter int BUFFER_ADDR_BITS = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_req_i,
    input  logic                        pause_i,
    input  logic [7:0]                  channels_i,
    output logic [BUFFER_ADDR_BITS-1:0] buf_addr_o,
    output logic                        buf_sel_o,
    input  logic [7:0]                  buf_data_i,
    input  logic                        buf_filled_i,
    output logic                        buf_empty_o,
    input  logic                        buf_empty_ack_i,
    output logic [15:0]                 sample_left_o,
    output logic [15:0]                 sample_right_o,
    output logic                        sample_valid_o,
    output logic                        underrun_o
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                 underrun_cnt_o
`endif
);

    typedef enum logic [1:0] {WAIT_FILL, FETCH, READY, SWAP} state_t;

    state_t      state_q;
    logic [2:0]  issue_cnt_q;
    logic [2:0]  cap_cnt_q;
    logic        rd_pend_q;
    logic        mono_q;
    logic [7:0]  byte_q [4];
    logic [2:0]  nbytes;
    logic        req_ok;

    always_comb begin
        nbytes = mono_q ? 3'd2 : 3'd4;
        req_ok = sample_req_i && !pause_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_FILL;
            issue_cnt_q    <= '0;
            cap_cnt_q      <= '0;
            rd_pend_q      <= 1'b0;
            mono_q         <= 1'b0;
            byte_q         <= '{default: '0};
            buf_addr_o     <= '0;
            buf_sel_o      <= 1'b0;
            buf_empty_o    <= 1'b0;
            sample_left_o  <= '0;
            sample_right_o <= '0;
            sample_valid_o <= 1'b0;
            underrun_o     <= 1'b0;
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
            underrun_cnt_o <= '0;
`endif
        end else begin
            sample_valid_o <= 1'b0;
            if (pause_i) begin
                sample_left_o  <= '0;
                sample_right_o <= '0;
            end
            if (req_ok && state_q != READY) begin
                underrun_o <= 1'b1;
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
                if (underrun_cnt_o != 16'hFFFF)
                    underrun_cnt_o <= underrun_cnt_o + 16'd1;
`endif
            end

            case (state_q)
                WAIT_FILL: begin
                    if (buf_filled_i) begin
                        buf_sel_o   <= ~buf_sel_o;
                        buf_addr_o  <= '0;
                        mono_q      <= (channels_i == 8'd1);
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        rd_pend_q   <= 1'b0;
                        state_q     <= FETCH;
                    end
                end

                FETCH: begin
                    // Issue and capture are tracked separately so a pause can stall the
                    // address stream while the read already in flight is still collected.
                    rd_pend_q <= 1'b0;
                    if (rd_pend_q) begin
                        byte_q[cap_cnt_q[1:0]] <= buf_data_i;
                        cap_cnt_q <= cap_cnt_q + 3'd1;
                        if (cap_cnt_q == nbytes - 3'd1)
                            state_q <= READY;
                    end
                    if (!pause_i && issue_cnt_q < nbytes) begin
                        rd_pend_q   <= 1'b1;
                        issue_cnt_q <= issue_cnt_q + 3'd1;
                        if ((issue_cnt_q + 3'd1) < nbytes)
                            buf_addr_o <= buf_addr_o + 1'b1;
                    end
                end

                READY: begin
                    if (req_ok) begin
                        sample_left_o  <= {byte_q[1], byte_q[0]};
                        sample_right_o <= mono_q ? {byte_q[1], byte_q[0]}
                                                 : {byte_q[3], byte_q[2]};
                        sample_valid_o <= 1'b1;
                        issue_cnt_q    <= '0;
                        cap_cnt_q      <= '0;
                        // buf_addr_o sits on the last byte read, so all-ones means the half is spent.
                        if (buf_addr_o == '1) begin
                            buf_empty_o <= 1'b1;
                            state_q     <= SWAP;
                        end else begin
                            buf_addr_o <= buf_addr_o + 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end

                SWAP: begin
                    if (buf_empty_ack_i) begin
                        buf_empty_o <= 1'b0;
                        state_q     <= WAIT_FILL;
                    end
                end

                default: state_q <= WAIT_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Self-checking bench for audio_sample_fetcher: byte-array RAM model and frame-pointer reference.
// Honours AUDIO_FETCH_UNDERRUN_CNT_EN when it is defined for the build.
module tb_audio_sample_fetcher;

    localparam int AB   = 9;
    localparam int HALF = 1 << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_req_i;
    logic          pause_i;
    logic [7:0]    channels_i;
    logic [AB-1:0] buf_addr_o;
    logic          buf_sel_o;
    logic [7:0]    buf_data_i;
    logic          buf_filled_i;
    logic          buf_empty_o;
    logic          buf_empty_ack_i;
    logic [15:0]   sample_left_o;
    logic [15:0]   sample_right_o;
    logic          sample_valid_o;
    logic          underrun_o;
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt_o;
`endif

    audio_sample_fetcher #(.BUFFER_ADDR_BITS(AB)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_req_i    (sample_req_i),
        .pause_i         (pause_i),
        .channels_i      (channels_i),
        .buf_addr_o      (buf_addr_o),
        .buf_sel_o       (buf_sel_o),
        .buf_data_i      (buf_data_i),
        .buf_filled_i    (buf_filled_i),
        .buf_empty_o     (buf_empty_o),
        .buf_empty_ack_i (buf_empty_ack_i),
        .sample_left_o   (sample_left_o),
        .sample_right_o  (sample_right_o),
        .sample_valid_o  (sample_valid_o),
        .underrun_o      (underrun_o)
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o  (underrun_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Two-half RAM; read data is registered, so it is valid one cycle after the address.
    logic [7:0] mem [2][HALF];
    always @(posedge clk) buf_data_i <= mem[buf_sel_o][buf_addr_o];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: active half, byte pointer of the next frame, frame width latched at fill.
    int          h;
    int          p;
    bit          mono_m;
    logic [15:0] last_l, last_r;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic fill_random(input int half);
        for (int i = 0; i < HALF; i++) mem[half][i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(buf_addr_o),     32'd0);
        chk({tag, "_sel"},   32'(buf_sel_o),      32'd0);
        chk({tag, "_empty"}, 32'(buf_empty_o),    32'd0);
        chk({tag, "_left"},  32'(sample_left_o),  32'd0);
        chk({tag, "_right"}, 32'(sample_right_o), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid_o), 32'd0);
        chk({tag, "_urun"},  32'(underrun_o),     32'd0);
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
        chk({tag, "_ucnt"},  32'(underrun_cnt_o), 32'd0);
`endif
    endtask

    // Writer side: inactive half already loaded; raise filled and expect the select to flip.
    task automatic hand_over(input string tag, input logic [7:0] ch);
        channels_i   = ch;
        buf_filled_i = 1'b1;
        tick();
        buf_filled_i = 1'b0;
        h      = 1 - h;
        p      = 0;
        mono_m = (ch == 8'd1);
        chk({tag, "_sel"},  32'(buf_sel_o),  32'(h));
        chk({tag, "_addr"}, 32'(buf_addr_o), 32'd0);
    endtask

    // A frame is prefetched within 5 cycles, so after 8 idle cycles a request must be served at once.
    task automatic get_pair(input string tag);
        logic [15:0] el, er;
        repeat (8) tick();
        el = {mem[h][p+1], mem[h][p]};
        er = mono_m ? el : {mem[h][p+3], mem[h][p+2]};
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        chk({tag, "_valid"}, 32'(sample_valid_o), 32'd1);
        chk({tag, "_left"},  32'(sample_left_o),  32'(el));
        chk({tag, "_right"}, 32'(sample_right_o), 32'(er));
        p += mono_m ? 2 : 4;
        last_l = el;
        last_r = er;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_req_i = 1'b0; pause_i = 1'b0; channels_i = 8'd2;
        buf_filled_i = 1'b0; buf_empty_ack_i = 1'b0;
        h = 0; p = 0; mono_m = 1'b0; last_l = '0; last_r = '0;
        fill_random(0);
        fill_random(1);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Stereo frame with known bytes in half 1.
        mem[1][0] = 8'h34; mem[1][1] = 8'h12; mem[1][2] = 8'h78; mem[1][3] = 8'h56;
        hand_over("fill1", 8'd2);
        get_pair("stereo0");

        // Pause lands during the next FETCH: address must hold, samples forced to zero.
        pause_i = 1'b1;
        tick();
        chk("pause_valid_drop", 32'(sample_valid_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            sample_req_i = 1'b1;
            tick();
            sample_req_i = 1'b0;
            tick();
            chk("pause_valid", 32'(sample_valid_o), 32'd0);
            chk("pause_left",  32'(sample_left_o),  32'd0);
            chk("pause_right", 32'(sample_right_o), 32'd0);
            chk("pause_addr",  32'(buf_addr_o),     32'(p));
            chk("pause_urun",  32'(underrun_o),     32'd0);
        end
        pause_i = 1'b0;
        get_pair("resume");

        // Drain the rest of the half: 128 stereo frames in total.
        while (p < HALF) begin
            if (p == HALF - 4) chk("empty_before_last", 32'(buf_empty_o), 32'd0);
            get_pair("stereo");
        end
        chk("empty_after_last", 32'(buf_empty_o), 32'd1);
        chk("urun_before_swap", 32'(underrun_o),  32'd0);

        // Request while waiting for the writer: underrun only.
        tick();
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        chk("swap_req_valid", 32'(sample_valid_o), 32'd0);
        chk("swap_req_left",  32'(sample_left_o),  32'(last_l));
        chk("swap_req_right", 32'(sample_right_o), 32'(last_r));
        chk("swap_req_urun",  32'(underrun_o),     32'd1);
        chk("swap_req_empty", 32'(buf_empty_o),    32'd1);
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
        chk("swap_req_ucnt",  32'(underrun_cnt_o), 32'd1);
`endif

        // Request coincident with the acknowledge: both take effect.
        sample_req_i = 1'b1;
        buf_empty_ack_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        buf_empty_ack_i = 1'b0;
        chk("ack_empty", 32'(buf_empty_o),    32'd0);
        chk("ack_valid", 32'(sample_valid_o), 32'd0);
        chk("ack_sel",   32'(buf_sel_o),      32'(h));
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
        chk("ack_ucnt",  32'(underrun_cnt_o), 32'd2);
`endif

        // Mono buffer in half 0; a mid-buffer channel change must not apply.
        fill_random(0);
        mem[0][0] = 8'hCD; mem[0][1] = 8'hAB;
        hand_over("fill0", 8'd1);
        get_pair("mono0");
        channels_i = 8'($urandom_range(2, 255));
        get_pair("mono1");

        // Request during FETCH: no valid, outputs held.
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        chk("fetch_req_valid", 32'(sample_valid_o), 32'd0);
        chk("fetch_req_left",  32'(sample_left_o),  32'(last_l));
        chk("fetch_req_right", 32'(sample_right_o), 32'(last_r));
`ifdef AUDIO_FETCH_UNDERRUN_CNT_EN
        chk("fetch_req_ucnt",  32'(underrun_cnt_o), 32'd3);
`endif
        get_pair("mono2");

        // Reset in the middle of fetching the next frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        h = 0;
        repeat (3) tick();
        chk("midrst_idle_sel", 32'(buf_sel_o), 32'd0);

        fill_random(1);
        hand_over("refill", 8'($urandom_range(2, 255)));
        get_pair("post_rst0");
        get_pair("post_rst1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
